// File: rtl/kv_refill_ctrl.sv
// Cache line refill controller: LRU touch on hits, victim pick,
// memory request and beat-by-beat data-array fill on misses.
module kv_refill_ctrl #(
   parameter int BEATS = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_req_valid,
   input  logic [3:0]                 i_req_index,
   input  logic [3:0]                 i_hitway,
   output logic                       o_req_ready,
   output logic [3:0]                 o_lru_index,
   input  logic [3:0]                 i_killmask,
   input  logic [3:0]                 i_validmask,
   output logic                       o_lru_upd_valid,
   output logic [3:0]                 o_lru_hitway,
   output logic                       o_mem_req_valid,
   input  logic                       i_mem_req_ready,
   output logic [3:0]                 o_mem_req_index,
   input  logic                       i_mem_resp_valid,
   output logic                       o_fill_we,
   output logic [3:0]                 o_fill_way,
   output logic [$clog2(BEATS)-1:0]   o_fill_beat,
   output logic                       o_done,
   output logic                       o_err
);

   localparam int BW = $clog2(BEATS);
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VICTIM,
      S_MEMREQ,
      S_FILL,
      S_UPDATE
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic [3:0]    victim_q, victim_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          hit_upd_q, hit_upd_d;
   logic [3:0]    hit_way_q, hit_way_d;
   logic [3:0]    hit_idx_q, hit_idx_d;
   logic          err_q, err_d;

   logic          accept;
   logic          hit_onehot;
   logic          is_miss;
   logic          resp_beat;
   logic [3:0]    victim_sel;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   assign accept     = i_req_valid && (state_q == S_IDLE);
   assign hit_onehot = is_onehot(i_hitway);
   assign is_miss    = (i_hitway == 4'd0);
   assign resp_beat  = (state_q == S_FILL) && i_mem_resp_valid;

   // Free ways win over the LRU victim; a corrupt killmask falls back to way 0.
   always_comb begin
      victim_sel = 4'b0001;
      priority case (1'b1)
         !i_validmask[0]:          victim_sel = 4'b0001;
         !i_validmask[1]:          victim_sel = 4'b0010;
         !i_validmask[2]:          victim_sel = 4'b0100;
         !i_validmask[3]:          victim_sel = 4'b1000;
         is_onehot(i_killmask):    victim_sel = i_killmask;
         default:                  victim_sel = 4'b0001;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= S_IDLE;
         idx_q     <= 4'd0;
         victim_q  <= 4'd0;
         beat_q    <= '0;
         hit_upd_q <= 1'b0;
         hit_way_q <= 4'd0;
         hit_idx_q <= 4'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         victim_q  <= victim_d;
         beat_q    <= beat_d;
         hit_upd_q <= hit_upd_d;
         hit_way_q <= hit_way_d;
         hit_idx_q <= hit_idx_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && is_miss) state_d = S_VICTIM;
         end
         S_VICTIM: state_d = S_MEMREQ;
         S_MEMREQ: begin
            if (i_mem_req_ready) state_d = S_FILL;
         end
         S_FILL: begin
            if (resp_beat && (beat_q == LAST)) state_d = S_UPDATE;
         end
         S_UPDATE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d     = idx_q;
      victim_d  = victim_q;
      beat_d    = beat_q;
      hit_upd_d = 1'b0;
      hit_way_d = hit_way_q;
      hit_idx_d = hit_idx_q;
      err_d     = 1'b0;
      if (accept) begin
         if (hit_onehot) begin
            hit_upd_d = 1'b1;
            hit_way_d = i_hitway;
            hit_idx_d = i_req_index;
         end else if (is_miss) begin
            idx_d = i_req_index;
         end else begin
            err_d = 1'b1;
         end
      end
      if (state_q == S_VICTIM) victim_d = victim_sel;
      if (resp_beat) begin
         beat_d = (beat_q == LAST) ? '0 : beat_q + BW'(1);
      end
   end

   always_comb begin
      o_req_ready     = (state_q == S_IDLE);
      o_lru_upd_valid = hit_upd_q || (state_q == S_UPDATE);
      o_lru_index     = hit_upd_q ? hit_idx_q : idx_q;
      o_lru_hitway    = 4'd0;
      if (hit_upd_q)                o_lru_hitway = hit_way_q;
      else if (state_q == S_UPDATE) o_lru_hitway = victim_q;
      o_mem_req_valid = (state_q == S_MEMREQ);
      o_mem_req_index = idx_q;
      o_fill_we       = resp_beat;
      o_fill_way      = (state_q == S_FILL) ? victim_q : 4'd0;
      o_fill_beat     = beat_q;
      o_done          = (state_q == S_UPDATE);
      o_err           = err_q;
   end

endmodule

// File: tb/tb_kv_refill_ctrl.sv
// Scoreboard bench for kv_refill_ctrl: directed stimulus pushes
// expectations, a negedge monitor pops them as outputs fire.
module tb_kv_refill_ctrl;

   localparam int BEATS = 4;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
   } pair_t;

   logic       i_clk = 1'b0;
   logic       i_rstn = 1'b0;
   logic       i_req_valid = 1'b0;
   logic [3:0] i_req_index = 4'd0;
   logic [3:0] i_hitway = 4'd0;
   logic       o_req_ready;
   logic [3:0] o_lru_index;
   logic [3:0] i_killmask = 4'd0;
   logic [3:0] i_validmask = 4'd0;
   logic       o_lru_upd_valid;
   logic [3:0] o_lru_hitway;
   logic       o_mem_req_valid;
   logic       i_mem_req_ready = 1'b0;
   logic [3:0] o_mem_req_index;
   logic       i_mem_resp_valid = 1'b0;
   logic       o_fill_we;
   logic [3:0] o_fill_way;
   logic [1:0] o_fill_beat;
   logic       o_done;
   logic       o_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   pair_t      lru_q[$];
   pair_t      fill_q[$];
   logic [3:0] mreq_q[$];
   int         done_q[$];
   int         err_q[$];

   kv_refill_ctrl #(.BEATS(BEATS)) dut (
      .i_clk            (i_clk),
      .i_rstn           (i_rstn),
      .i_req_valid      (i_req_valid),
      .i_req_index      (i_req_index),
      .i_hitway         (i_hitway),
      .o_req_ready      (o_req_ready),
      .o_lru_index      (o_lru_index),
      .i_killmask       (i_killmask),
      .i_validmask      (i_validmask),
      .o_lru_upd_valid  (o_lru_upd_valid),
      .o_lru_hitway     (o_lru_hitway),
      .o_mem_req_valid  (o_mem_req_valid),
      .i_mem_req_ready  (i_mem_req_ready),
      .o_mem_req_index  (o_mem_req_index),
      .i_mem_resp_valid (i_mem_resp_valid),
      .o_fill_we        (o_fill_we),
      .o_fill_way       (o_fill_way),
      .o_fill_beat      (o_fill_beat),
      .o_done           (o_done),
      .o_err            (o_err)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unexpected pulse expected none (cycle %0d)",
               nm, cyc);
   endtask

   // Monitor: every output event must match the oldest expectation.
   always @(negedge i_clk) begin
      if (i_rstn) begin
         if (o_lru_upd_valid) begin
            if (lru_q.size() == 0) unexpected("lru_upd");
            else begin
               pair_t e;
               e = lru_q.pop_front();
               chk("lru_index", o_lru_index, e.a);
               chk("lru_hitway", o_lru_hitway, e.b);
            end
         end
         if (o_fill_we) begin
            if (fill_q.size() == 0) unexpected("fill_we");
            else begin
               pair_t e;
               e = fill_q.pop_front();
               chk("fill_way", o_fill_way, e.a);
               chk("fill_beat", o_fill_beat, e.b);
            end
         end
         if (o_done) begin
            if (done_q.size() == 0) unexpected("done");
            else chk("done_cycle", cyc, done_q.pop_front());
         end
         if (o_err) begin
            if (err_q.size() == 0) unexpected("err");
            else chk("err_cycle", cyc, err_q.pop_front());
         end
         if (o_mem_req_valid) begin
            if (mreq_q.size() == 0) unexpected("mem_req");
            else begin
               chk("mem_req_index", o_mem_req_index, mreq_q[0]);
               if (i_mem_req_ready) void'(mreq_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_hit(input logic [3:0] idx, input logic [3:0] way);
      i_req_valid = 1'b1;
      i_req_index = idx;
      i_hitway    = way;
      lru_q.push_back('{idx, way});
      tick();
      i_req_valid = 1'b0;
   endtask

   task automatic do_err(input logic [3:0] idx, input logic [3:0] way);
      i_req_valid = 1'b1;
      i_req_index = idx;
      i_hitway    = way;
      err_q.push_back(cyc + 1);
      tick();
      i_req_valid = 1'b0;
   endtask

   task automatic do_miss(input logic [3:0] idx, input logic [3:0] vm,
                          input logic [3:0] km, input logic [3:0] vic,
                          input int stall, input int gap);
      int t;
      t = cyc;
      i_req_valid = 1'b1;
      i_req_index = idx;
      i_hitway    = 4'd0;
      i_validmask = vm;
      i_killmask  = km;
      mreq_q.push_back(idx);
      for (int b = 0; b < BEATS; b++) fill_q.push_back('{vic, 4'(b)});
      lru_q.push_back('{idx, vic});
      done_q.push_back(t + 3 + stall + BEATS * (gap + 1));
      tick();
      i_req_valid = 1'b0;
      chk("victim_lru_index", o_lru_index, idx);
      chk("busy_not_ready", o_req_ready, 1'b0);
      tick();
      i_mem_req_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
         i_mem_resp_valid = 1'b1;
         tick();
      end
      i_mem_resp_valid = 1'b0;
      i_mem_req_ready  = 1'b1;
      tick();
      i_mem_req_ready = 1'b0;
      for (int b = 0; b < BEATS; b++) begin
         for (int g = 0; g < gap; g++) tick();
         i_mem_resp_valid = 1'b1;
         tick();
         i_mem_resp_valid = 1'b0;
      end
      tick();
      chk("idle_after_done", o_req_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_req_ready", o_req_ready, 1'b1);
      chk("rst_lru_upd", o_lru_upd_valid, 1'b0);
      chk("rst_lru_index", o_lru_index, 4'd0);
      chk("rst_lru_hitway", o_lru_hitway, 4'd0);
      chk("rst_mem_req", o_mem_req_valid, 1'b0);
      chk("rst_fill_we", o_fill_we, 1'b0);
      chk("rst_done_err", {o_done, o_err}, 2'b00);
      tick();
      tick();
      i_rstn = 1'b1;
      tick();

      // Hit, then back-to-back hits with stray beats in IDLE
      do_hit(4'h3, 4'b0100);
      chk("hit_ready", o_req_ready, 1'b1);
      i_mem_resp_valid = 1'b1;
      do_hit(4'h7, 4'b0001);
      do_hit(4'hA, 4'b1000);
      do_hit(4'hF, 4'b0010);
      i_mem_resp_valid = 1'b0;
      tick();

      // Malformed hitway
      do_err(4'h2, 4'b0011);
      chk("err_ready", o_req_ready, 1'b1);
      tick();
      tick();

      do_miss(4'h1, 4'b1011, 4'b0001, 4'b0100, 0, 0);
      do_miss(4'h4, 4'b1111, 4'b1000, 4'b1000, 0, 0);
      do_miss(4'h6, 4'b1111, 4'b0110, 4'b0001, 0, 0);
      do_miss(4'hC, 4'b1110, 4'b0100, 4'b0001, 3, 2);

      // Hit immediately followed by a miss
      do_hit(4'h5, 4'b0010);
      do_miss(4'h9, 4'b0111, 4'b0010, 4'b1000, 0, 0);

      // Reset in the middle of a refill
      i_req_valid = 1'b1;
      i_req_index = 4'hB;
      i_hitway    = 4'd0;
      i_validmask = 4'b1101;
      mreq_q.push_back(4'hB);
      fill_q.push_back('{4'b0010, 4'd0});
      fill_q.push_back('{4'b0010, 4'd1});
      tick();
      i_req_valid     = 1'b0;
      tick();
      i_mem_req_ready = 1'b1;
      tick();
      i_mem_req_ready  = 1'b0;
      i_mem_resp_valid = 1'b1;
      tick();
      tick();
      i_mem_resp_valid = 1'b0;
      #2;
      i_rstn = 1'b0;
      #1;
      chk("midrst_ready", o_req_ready, 1'b1);
      chk("midrst_done", o_done, 1'b0);
      chk("midrst_fill_way", o_fill_way, 4'd0);
      tick();
      i_rstn = 1'b1;
      i_mem_resp_valid = 1'b1;
      tick();
      tick();
      i_mem_resp_valid = 1'b0;
      chk("postrst_ready", o_req_ready, 1'b1);
      tick();

      do_hit(4'hE, 4'b1000);
      tick();
      tick();

      chk("lru_left", lru_q.size(), 0);
      chk("fill_left", fill_q.size(), 0);
      chk("mreq_left", mreq_q.size(), 0);
      chk("done_left", done_q.size(), 0);
      chk("err_left", err_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
